// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared ID/EX pipeline constants: operand and address widths, control field widths,
// and bit positions of the packed EX control field.
package id_ex_pipe_reg_pkg;

    localparam int DATA_W      = 32;
    localparam int PC_W        = 30;
    localparam int RA_W        = 5;
    localparam int WB_W        = 2;
    localparam int M_W         = 3;
    localparam int ALUOP_W     = 2;
    localparam int EX_W        = ALUOP_W + 2;

    localparam int REGDST_BIT  = 0;
    localparam int ALUSRC_BIT  = 1;
    localparam int ALUOP_LSB   = 2;
    localparam int MEMREAD_BIT = 1;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-EX bundle: decode-side inputs, registered EX-side outputs and stall/flush controls.
// slave = the pipeline register, master = whoever drives decode and consumes EX.
import id_ex_pipe_reg_pkg::*;

interface id_ex_pipe_reg_if #(
    parameter int DATA_W  = id_ex_pipe_reg_pkg::DATA_W,
    parameter int PC_W    = id_ex_pipe_reg_pkg::PC_W,
    parameter int RA_W    = id_ex_pipe_reg_pkg::RA_W,
    parameter int WB_W    = id_ex_pipe_reg_pkg::WB_W,
    parameter int M_W     = id_ex_pipe_reg_pkg::M_W,
    parameter int ALUOP_W = id_ex_pipe_reg_pkg::ALUOP_W
);
    logic                 id_valid;
    logic                 stall_in;
    logic                 flush_in;
    logic [PC_W-1:0]      PC_4_;
    logic [DATA_W-1:0]    ReadData1_;
    logic [DATA_W-1:0]    ReadData2_;
    logic [DATA_W-1:0]    extended_offset_;
    logic [RA_W-1:0]      rs_;
    logic [RA_W-1:0]      WriteChoice1_;
    logic [RA_W-1:0]      WriteChoice2_;
    logic [WB_W-1:0]      WB_;
    logic [M_W-1:0]       M_;
    logic [ALUOP_W+1:0]   EX_;

    logic                 valid;
    logic [PC_W-1:0]      PC_4;
    logic [DATA_W-1:0]    ReadData1;
    logic [DATA_W-1:0]    ReadData2;
    logic [DATA_W-1:0]    extended_offset;
    logic [RA_W-1:0]      WriteChoice1;
    logic [RA_W-1:0]      WriteChoice2;
    logic [WB_W-1:0]      WB;
    logic [M_W-1:0]       M;
    logic                 RegDst;
    logic                 ALUSrc;
    logic [ALUOP_W-1:0]   ALUOp;
    logic                 hazard_stall;
    logic                 stall_out;

    modport slave (
        input  id_valid, stall_in, flush_in, PC_4_, ReadData1_, ReadData2_, extended_offset_,
               rs_, WriteChoice1_, WriteChoice2_, WB_, M_, EX_,
        output valid, PC_4, ReadData1, ReadData2, extended_offset, WriteChoice1, WriteChoice2,
               WB, M, RegDst, ALUSrc, ALUOp, hazard_stall, stall_out
    );

    modport master (
        output id_valid, stall_in, flush_in, PC_4_, ReadData1_, ReadData2_, extended_offset_,
               rs_, WriteChoice1_, WriteChoice2_, WB_, M_, EX_,
        input  valid, PC_4, ReadData1, ReadData2, extended_offset, WriteChoice1, WriteChoice2,
               WB, M, RegDst, ALUSrc, ALUOp, hazard_stall, stall_out
    );

endinterface

// File: rtl/hazard_detect_lu.sv
// Load-use comparator: flags a load in the producer stage whose destination feeds the consumer.
// Purely combinational; register 0 never matches, and a flush suppresses the request.
module hazard_detect_lu #(
    parameter int RA_W = 5
) (
    input  logic            prod_valid,
    input  logic            prod_memread,
    input  logic [RA_W-1:0] prod_rt,
    input  logic            cons_valid,
    input  logic [RA_W-1:0] cons_rs,
    input  logic [RA_W-1:0] cons_rt,
    input  logic            flush,
    output logic            hazard
);

    always_comb begin
        hazard = prod_valid & prod_memread & (prod_rt != '0) & cons_valid &
                 ((prod_rt == cons_rs) | (prod_rt == cons_rt)) & ~flush;
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, stall hold, branch flush and load-use bubble insertion.
// Every field has 1-cycle latency; hazard_stall/stall_out are combinational from EX state and decode.
import id_ex_pipe_reg_pkg::*;

module id_ex_pipe_reg #(
    parameter int DATA_W      = id_ex_pipe_reg_pkg::DATA_W,
    parameter int PC_W        = id_ex_pipe_reg_pkg::PC_W,
    parameter int RA_W        = id_ex_pipe_reg_pkg::RA_W,
    parameter int WB_W        = id_ex_pipe_reg_pkg::WB_W,
    parameter int M_W         = id_ex_pipe_reg_pkg::M_W,
    parameter int ALUOP_W     = id_ex_pipe_reg_pkg::ALUOP_W,
    parameter int MEMREAD_BIT = id_ex_pipe_reg_pkg::MEMREAD_BIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    id_ex_pipe_reg_if.slave       io
);

    logic                valid_q,  valid_d;
    logic [PC_W-1:0]     pc_4_q,   pc_4_d;
    logic [DATA_W-1:0]   rd1_q,    rd1_d;
    logic [DATA_W-1:0]   rd2_q,    rd2_d;
    logic [DATA_W-1:0]   ext_q,    ext_d;
    logic [RA_W-1:0]     wc1_q,    wc1_d;
    logic [RA_W-1:0]     wc2_q,    wc2_d;
    logic [WB_W-1:0]     wb_q,     wb_d;
    logic [M_W-1:0]      m_q,      m_d;
    logic [ALUOP_W+1:0]  ex_q,     ex_d;
    logic                hazard;

    hazard_detect_lu #(.RA_W(RA_W)) u_hazard (
        .prod_valid   (valid_q),
        .prod_memread (m_q[MEMREAD_BIT]),
        .prod_rt      (wc1_q),
        .cons_valid   (io.id_valid),
        .cons_rs      (io.rs_),
        .cons_rt      (io.WriteChoice1_),
        .flush        (io.flush_in),
        .hazard       (hazard)
    );

    always_comb begin
        valid_d = valid_q;
        pc_4_d  = pc_4_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        ext_d   = ext_q;
        wc1_d   = wc1_q;
        wc2_d   = wc2_q;
        wb_d    = wb_q;
        m_d     = m_q;
        ex_d    = ex_q;
        // Flush and bubble both kill the control bits so the dead slot cannot write state.
        if (io.flush_in || (!io.stall_in && hazard)) begin
            valid_d = 1'b0;
            wb_d    = '0;
            m_d     = '0;
            ex_d    = '0;
        end else if (!io.stall_in) begin
            valid_d = io.id_valid;
            pc_4_d  = io.PC_4_;
            rd1_d   = io.ReadData1_;
            rd2_d   = io.ReadData2_;
            ext_d   = io.extended_offset_;
            wc1_d   = io.WriteChoice1_;
            wc2_d   = io.WriteChoice2_;
            wb_d    = io.id_valid ? io.WB_ : '0;
            m_d     = io.id_valid ? io.M_  : '0;
            ex_d    = io.id_valid ? io.EX_ : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_4_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            ext_q   <= '0;
            wc1_q   <= '0;
            wc2_q   <= '0;
            wb_q    <= '0;
            m_q     <= '0;
            ex_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_4_q  <= pc_4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            ext_q   <= ext_d;
            wc1_q   <= wc1_d;
            wc2_q   <= wc2_d;
            wb_q    <= wb_d;
            m_q     <= m_d;
            ex_q    <= ex_d;
        end
    end

    assign io.valid           = valid_q;
    assign io.PC_4            = pc_4_q;
    assign io.ReadData1       = rd1_q;
    assign io.ReadData2       = rd2_q;
    assign io.extended_offset = ext_q;
    assign io.WriteChoice1    = wc1_q;
    assign io.WriteChoice2    = wc2_q;
    assign io.WB              = wb_q;
    assign io.M               = m_q;
    assign io.RegDst          = ex_q[REGDST_BIT];
    assign io.ALUSrc          = ex_q[ALUSRC_BIT];
    assign io.ALUOp           = ex_q[ALUOP_LSB +: ALUOP_W];
    assign io.hazard_stall    = hazard;
    assign io.stall_out       = hazard | io.stall_in;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register, successor to the fixed-width ID/EX latch. Adds a valid bit, hold on downstream stall, flush on taken branch, and a built-in load-use hazard detector that inserts a single bubble and stalls IF/ID. Sits between the decode stage (register file, sign-extend, control unit) and the EX stage (ALU, RegDst mux).

Parameters:
DATA_W, 32, width of ReadData1/ReadData2/extended_offset
PC_W, 30, width of PC+4 word address (bits 31:2)
RA_W, 5, register address width (rs/rt/rd)
WB_W, 2, WB control field width
M_W, 3, M control field width
ALUOP_W, 2, ALUOp width
MEMREAD_BIT, 1, index of the MemRead bit within the M field

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a real instruction
stall_in  in  1  downstream (MEM) stall; hold this register
flush_in  in  1  taken branch/jump; kill the instruction entering EX
PC_4_  in  PC_W  PC+4 from decode
ReadData1_  in  DATA_W  rs operand
ReadData2_  in  DATA_W  rt operand
extended_offset_  in  DATA_W  sign-extended immediate
rs_  in  RA_W  instruction rs field, hazard compare only
WriteChoice1_  in  RA_W  rt field
WriteChoice2_  in  RA_W  rd field
WB_  in  WB_W  writeback controls
M_  in  M_W  memory controls
EX_  in  ALUOP_W+2  {ALUOp, ALUSrc, RegDst}
valid  out  1  EX stage holds a real instruction
PC_4, ReadData1, ReadData2, extended_offset, WriteChoice1, WriteChoice2, WB, M  out  matching widths  registered copies
RegDst  out  1  EX_[0]
ALUSrc  out  1  EX_[1]
ALUOp  out  ALUOP_W  EX_[ALUOP_W+1:2]
hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle
stall_out  out  1  combinational; hazard_stall | stall_in

Behaviour:
- Reset: when rst_n is low, all registered outputs go to 0 immediately and asynchronously, including valid. Deassertion takes effect on the next clk edge.
- Load-use detect (combinational): hazard_stall = valid & M[MEMREAD_BIT] & (WriteChoice1 != 0) & id_valid & ((WriteChoice1 == rs_) | (WriteChoice1 == WriteChoice1_)) & !flush_in.
- Register 0 never causes a hazard.
- Update priority at each rising clk edge, highest first:
  1. flush_in: valid <= 0; WB, M, RegDst, ALUSrc, ALUOp <= 0; data fields hold. Flush overrides stall_in.
  2. stall_in: every register holds, including valid.
  3. hazard_stall: insert a bubble. Valid and controls are zeroed as in a flush; data fields hold.
  4. Otherwise load: every field takes its input; valid <= id_valid; controls are taken only if id_valid, else zeroed.
- Bubble length is exactly 1 cycle. After the bubble the EX stage holds the bubble, so hazard_stall drops and the held decode instruction loads on the next edge.
- Latency is 1 cycle for every field. There is no combinational path from inputs to registered outputs.
- Invariant: valid == 0 implies WB == 0, M == 0, RegDst == 0, ALUSrc == 0 and ALUOp == 0. A bubble can never write the register file or memory.
- Reset asserted mid-stall or mid-bubble: outputs clear immediately. hazard_stall evaluates to 0 because valid is 0.

Decomposition:
- Shared pipeline package holds: width constants (DATA_W, PC_W, RA_W), control-field widths (WB_W, M_W, ALUOP_W), the EX_ bit positions (REGDST_BIT=0, ALUSRC_BIT=1, ALUOP_LSB=2), and MEMREAD_BIT.
- One sub-module, hazard_detect_lu: purely combinational load-use comparator. It is reused later by the EX/MEM stage for load-to-branch checks.
- The register bank stays in the top module.

Test Plan:
- Reset: drive nonzero inputs, pulse rst_n low between clock edges -> every output reads 0 at once, with no clk edge. Release, then one edge with id_valid=1 -> outputs equal the inputs and valid=1.
- Plain load: PC_4_=0x100, ReadData1_=0xDEADBEEF, EX_=4'b1011, id_valid=1 -> next edge RegDst=1, ALUSrc=1, ALUOp=2'b10, PC_4=0x100, hazard_stall=0.
- Load-use: EX holds a load (M[1]=1, WriteChoice1=5, valid=1); decode presents rs_=5 -> hazard_stall=1 and stall_out=1. Next edge: valid=0, controls 0. Following cycle: hazard_stall=0 and the decode instruction loads.
- No false hazard: EX load with WriteChoice1=0, rs_=0 -> hazard_stall=0. EX non-load (M[1]=0) with matching rt -> hazard_stall=0.
- Stall hold: stall_in=1 for 3 cycles while inputs change -> all outputs constant and stall_out=1. Release -> loads the current inputs.
- Flush vs stall: flush_in=1 and stall_in=1 on the same edge -> valid=0 and all controls 0. Also flush_in=1 during a load-use condition -> hazard_stall=0 and a bubble is written.
